// File: rtl/lut_layer_pkg.sv
// rtl/lut_layer_pkg.sv - shared types and helpers for the LUT neuron layer
package lut_layer_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int tbl_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - one neuron's truth table: sync write, async read
module lut_neuron_ram
    import lut_layer_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    localparam int DEPTH = tbl_depth(IN_BITS);

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_layer.sv
// rtl/lut_neuron_layer.sv - reprogrammable layer of N truth-table neurons, 2-stage pipeline
module lut_neuron_layer
    import lut_layer_pkg::*;
#(
    parameter int N        = 4,
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int NIDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*IN_BITS-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*OUT_BITS-1:0] out_data,
    input  logic                  cfg_we,
    output logic                  cfg_ready,
    input  logic [NIDX_W-1:0]     cfg_neuron,
    input  logic [IN_BITS-1:0]    cfg_addr,
    input  logic [OUT_BITS-1:0]   cfg_data,
    output logic                  busy
);

    localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(tbl_depth(IN_BITS) - 1);

    state_t                  state_q, state_d;
    logic [IN_BITS-1:0]      init_cnt_q, init_cnt_d;
    logic                    v1_q;
    logic [N*IN_BITS-1:0]    addr_q;
    logic                    out_valid_q;
    logic [N*OUT_BITS-1:0]   out_data_q;
    logic [N*OUT_BITS-1:0]   rd_data;
    logic                    adv;
    logic [IN_BITS-1:0]      wr_addr;
    logic [OUT_BITS-1:0]     wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        busy       = 1'b0;
        cfg_ready  = 1'b0;
        case (state_q)
            INIT: begin
                busy       = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN:     cfg_ready = 1'b1;
            default: state_d   = INIT;
        endcase
    end

    // Both stages move together; a full output stage blocks everything behind it.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv && (state_q == RUN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            v1_q        <= in_valid && in_ready;
            addr_q      <= in_data;
            out_valid_q <= v1_q;
            out_data_q  <= rd_data;
        end
    end

    // During INIT every table is cleared in parallel; in RUN only the selected one is written.
    assign wr_addr = (state_q == INIT) ? init_cnt_q : cfg_addr;
    assign wr_data = (state_q == INIT) ? '0 : cfg_data;

    for (genvar i = 0; i < N; i++) begin : g_neuron
        logic we;
        assign we = (state_q == INIT) || (cfg_we && (cfg_neuron == NIDX_W'(i)));

        lut_neuron_ram #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk     (clk),
            .we_i    (we),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .raddr_i (addr_q[i*IN_BITS +: IN_BITS]),
            .rdata_o (rd_data[i*OUT_BITS +: OUT_BITS])
        );
    end

endmodule
